// File: rtl/keypad_scanner.sv
// Row-scanning controller for a 4x4 matrix keypad: drives one row low at a time,
// debounces the column returns and reports each accepted press with a one-cycle strobe.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1200,
    parameter int DEBOUNCE_CNT = 400
) (
    input  logic       clk,
    input  logic       rstn,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t           state, state_next;
    logic [3:0]       col_meta, col_s;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx, row_idx_next;
    logic [1:0]       cand_col, cand_col_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]       key_code_next;
    logic             key_valid_next, key_held_next;
    logic             sample, hit;
    logic [1:0]       hit_col;

    // The divider wraps on every sample, and the driven row only ever changes on a
    // sample, so wrapping here also restarts the count whenever the row moves.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_meta  <= 4'hF;
            col_s     <= 4'hF;
            div_cnt   <= '0;
            state     <= SCAN;
            row_idx   <= 2'd0;
            cand_col  <= 2'd0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            col_meta  <= col_n;
            col_s     <= col_meta;
            div_cnt   <= sample ? '0 : div_cnt + 1'b1;
            state     <= state_next;
            row_idx   <= row_idx_next;
            cand_col  <= cand_col_next;
            cnt       <= cnt_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

    assign sample  = (div_cnt == DIV_LAST);
    assign hit     = ~&col_s;
    assign cnt_inc = cnt + 1'b1;
    // row_idx stays on the candidate row while debouncing or held, so it is the driven row
    assign row_n   = ~(4'b0001 << row_idx);

    always_comb begin
        hit_col = 2'd3;
        if (!col_s[0])      hit_col = 2'd0;
        else if (!col_s[1]) hit_col = 2'd1;
        else if (!col_s[2]) hit_col = 2'd2;
    end

    always_comb begin
        state_next     = state;
        row_idx_next   = row_idx;
        cand_col_next  = cand_col;
        cnt_next       = cnt;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_held_next  = key_held;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (hit) begin
                        cand_col_next = hit_col;
                        if (DEBOUNCE_CNT == 1) begin
                            key_code_next  = {row_idx, hit_col};
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = '0;
                            state_next     = HELD;
                        end else begin
                            cnt_next   = CNT_W'(1);
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        row_idx_next = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (hit && (hit_col == cand_col)) begin
                        if (cnt_inc == CNT_LAST) begin
                            key_code_next  = {row_idx, cand_col};
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = '0;
                            state_next     = HELD;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next     = '0;
                        row_idx_next = row_idx + 2'd1;
                        state_next   = SCAN;
                    end
                end
                HELD: begin
                    // Only the held column matters here; other keys are ignored until release.
                    if (!col_s[cand_col]) begin
                        cnt_next = '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        cnt_next      = '0;
                        key_held_next = 1'b0;
                        row_idx_next  = row_idx + 2'd1;
                        state_next    = SCAN;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3: a keypad matrix model
// feeds the columns and a queue of expected key codes is matched against each strobe.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        prev_valid = 1'b0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk),
        .rstn(rstn),
        .row_n(row_n),
        .col_n(col_n),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    // keys[r*4+c] set means the key at row r, column c is physically down
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_output(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && key_valid) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_valid", 16'(key_valid), 16'd0);
            end else begin
                exp_code = exp_q.pop_front();
                check_output("key_code_on_valid", 16'(key_code), 16'(exp_code));
            end
            check_output("valid_consecutive", 16'(prev_valid), 16'd0);
        end
        prev_valid <= rstn && key_valid;
    end

    function automatic logic [3:0] row_pattern(input int r);
        logic [3:0] p;
        p = 4'b0001 << r;
        return ~p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sample();
        do tick(); while (cyc % 4 != 0);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!key_valid && n < budget) begin
            tick();
            n++;
        end
        check_output("valid_timeout", 16'(key_valid), 16'd1);
    endtask

    task automatic apply_stimulus(input logic [15:0] k);
        keys = k;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and idle scan
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_row_n", 16'(row_n), 16'hE);
        check_output("reset_key_code", 16'(key_code), 16'h0);
        check_output("reset_key_valid", 16'(key_valid), 16'h0);
        check_output("reset_key_held", 16'(key_held), 16'h0);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_output("idle_row_n", 16'(row_n), 16'(row_pattern((cyc / 4) % 4)));
        end

        // Clean press on row 1, column 2
        apply_stimulus(16'h0040);
        exp_q.push_back(4'h6);
        wait_sample();
        check_output("press_row_reached", 16'(row_n), 16'hD);
        wait_sample();
        check_output("press_row_frozen1", 16'(row_n), 16'hD);
        wait_sample();
        check_output("press_row_frozen2", 16'(row_n), 16'hD);
        check_output("press_no_held_yet", 16'(key_held), 16'h0);
        check_output("press_no_valid_yet", 16'(key_valid), 16'h0);
        wait_sample();
        check_output("press_valid", 16'(key_valid), 16'h1);
        check_output("press_code", 16'(key_code), 16'h6);
        check_output("press_held", 16'(key_held), 16'h1);
        tick();
        check_output("press_valid_drop", 16'(key_valid), 16'h0);
        apply_stimulus(16'h0000);
        wait_sample();
        check_output("release_held1", 16'(key_held), 16'h1);
        wait_sample();
        check_output("release_held2", 16'(key_held), 16'h1);
        wait_sample();
        check_output("release_held_low", 16'(key_held), 16'h0);
        check_output("release_row_n", 16'(row_n), 16'hB);
        check_output("release_code_kept", 16'(key_code), 16'h6);

        // Bounce on row 3, column 0
        apply_stimulus(16'h1000);
        wait_sample();
        check_output("bounce_row3", 16'(row_n), 16'h7);
        wait_sample();
        check_output("bounce_row3_debounce", 16'(row_n), 16'h7);
        apply_stimulus(16'h0000);
        wait_sample();
        check_output("bounce_resume_row0", 16'(row_n), 16'hE);
        apply_stimulus(16'h1000);
        wait_sample();
        check_output("bounce_row1", 16'(row_n), 16'hD);
        apply_stimulus(16'h0000);

        // Priority: row 0 cols 1,3 and row 2 col 0, pressed while row 3 is driven
        wait_sample();
        wait_sample();
        check_output("prio_row3", 16'(row_n), 16'h7);
        apply_stimulus(16'h010A);
        exp_q.push_back(4'h1);
        wait_valid(20);
        check_output("prio_code", 16'(key_code), 16'h1);
        check_output("prio_held", 16'(key_held), 16'h1);
        check_output("prio_row_n", 16'(row_n), 16'hE);

        // Release bounce on held column 1
        apply_stimulus(16'h0000);
        for (int i = 0; i < 2; i++) begin
            wait_sample();
            check_output("rbounce_high", 16'(key_held), 16'h1);
        end
        apply_stimulus(16'h0002);
        wait_sample();
        check_output("rbounce_low", 16'(key_held), 16'h1);
        apply_stimulus(16'h0000);
        for (int i = 0; i < 2; i++) begin
            wait_sample();
            check_output("rbounce_final_high", 16'(key_held), 16'h1);
        end
        wait_sample();
        check_output("rbounce_released", 16'(key_held), 16'h0);
        check_output("rbounce_row_n", 16'(row_n), 16'hD);

        // Reset during debounce of row 1, column 3
        apply_stimulus(16'h0080);
        wait_sample();
        tick();
        rstn = 1'b0;
        #1;
        check_output("midrst_row_n", 16'(row_n), 16'hE);
        check_output("midrst_key_code", 16'(key_code), 16'h0);
        check_output("midrst_key_valid", 16'(key_valid), 16'h0);
        check_output("midrst_key_held", 16'(key_held), 16'h0);
        repeat (3) tick();
        apply_stimulus(16'h0000);
        rstn = 1'b1;
        repeat (40) tick();
        check_output("midrst_after_row_n", 16'(row_n), 16'(row_pattern((cyc / 4) % 4)));
        check_output("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
